sram_wb_bridge: RTL and testbench
=================================

Name: sram_wb_bridge

Overview:
- 32-bit Wishbone classic slave that acts as the initiator for the dual-port 64x256 SRAM macro (byte-masked write port, independent read port).
- Splits 32-bit bus accesses onto 64-bit SRAM rows:
  - writes go through the write port with a byte mask;
  - reads go through the read port, and the bridge absorbs the macro's one-cycle read latency.
- Sits between the debugger SoC Wishbone interconnect (address decode done upstream) and one SRAM instance.

Parameters:
- ADDR_WIDTH, 8, SRAM row address width (rows = 1<<ADDR_WIDTH).
- DATA_WIDTH, 64, SRAM row width; fixed at 2x bus width.
- NUM_WMASKS, 8, SRAM byte-mask width (DATA_WIDTH/8).

Ports:
- clk  in  1  clock; also drives SRAM write_clk/read_clk externally.
- rst_n  in  1  synchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  ADDR_WIDTH+3  byte address; [2] selects half, [ADDR_WIDTH+2:3] selects row, [1:0] ignored.
- wb_sel_i  in  4  byte selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  one-cycle acknowledge.
- sram_write_csb  out  1  write-port chip select, active low.
- sram_write_web  out  1  write enable, active low.
- sram_write_wmask  out  NUM_WMASKS  byte mask.
- sram_write_addr  out  ADDR_WIDTH  write row.
- sram_write_data  out  DATA_WIDTH  write data.
- sram_read_csb  out  1  read-port chip select, active low.
- sram_read_addr  out  ADDR_WIDTH  read row.
- sram_read_data  in  DATA_WIDTH  read data, valid the cycle after the SRAM capture edge.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values:
  - sram_write_csb = 1, sram_read_csb = 1, sram_write_web = 1;
  - mask = 0, addresses = 0, sram_write_data = 0;
  - wb_ack_o = 0, wb_dat_o = 0;
  - FSM in IDLE.
- Reset asserted mid-operation: abandon the access, no ack, both csb high on the next cycle.
- All SRAM-side outputs are registered.
- FSM states: IDLE, WR, RD_ADDR, RD_CAP, ACK.
- IDLE:
  - On cyc & stb at edge E0, register the row and half (adr[2]).
  - Write → WR:
    - sram_write_csb = 0, sram_write_web = 0;
    - sram_write_data = {wb_dat_i, wb_dat_i};
    - mask = {sel, 4'b0} if half = 1, else {4'b0, sel}.
  - Read → RD_ADDR: sram_read_csb = 0, sram_read_addr = row.
- WR: SRAM captures at E1. Deassert csb/web, assert wb_ack_o → ACK.
- RD_ADDR: SRAM captures at E1. Deassert read_csb → RD_CAP.
- RD_CAP: at E2, wb_dat_o = half ? sram_read_data[63:32] : [31:0]; assert ack → ACK.
- Latency from the request-sampling edge:
  - write ack high after E1 (2 edges);
  - read ack high after E2 (3 edges).
- ACK:
  - ack is high for exactly one cycle, then deasserts.
  - stb is ignored while ack is high, so a held strobe cannot retrigger.
  - Return to IDLE; next request accepted at the following edge.
  - Minimum spacing: write every 3 cycles, read every 4.
- wb_dat_o holds its value between reads; it is not cleared on writes.
- Write with sel = 0: SRAM cycle still issued with mask 0 (no data change); ack as normal.
- wb_cyc_i low at the edge where ack would be generated: the SRAM access still completes, ack is suppressed, go to IDLE.
- Both csb are never low simultaneously.
- Address wrap: the top row (all ones) is treated like any other row; bits above ADDR_WIDTH+2 are not present.

Optional Feature:
- Macro: SRAM_WB_LINEBUF_EN.
- Defined — one-entry row buffer:
  - Holds 64-bit data, row tag and a valid bit.
  - Filled on every RD_CAP.
  - A read whose row matches a valid tag is acked after E0 (1 edge) from the buffer, with no SRAM access (read_csb stays high); the half is selected as normal.
  - Any write to the tagged row clears valid in the same edge the write is issued.
  - Reset clears valid.
- Undefined: no buffer; every read takes the 3-edge path.

Test Plan:
- Reset: hold rst_n = 0 two cycles with stb = 1 → both csb = 1, web = 1, ack = 0, dat_o = 0; no SRAM access.
- Write adr = 0x00C, sel = 0xF, dat = 0xDEADBEEF → one cycle with write_csb = 0, web = 0, addr = 1, wmask = 0xF0, write_data[63:32] = 0xDEADBEEF; ack after 2 edges, high exactly 1 cycle.
- Read row 1 with model returning 0x11112222_33334444:
  - adr = 0x00C → dat_o = 0x11112222;
  - adr = 0x008 → dat_o = 0x33334444;
  - read_csb low 1 cycle, ack 3 edges after request.
- Byte write sel = 0x4 to adr 0x7F8 (row 255, low half) → wmask = 0x04, addr = 0xFF; ack; sel = 0 write → wmask = 0x00, ack still returned.
- Abort: drop cyc after a read is sampled → read_csb pulses once, no ack, next write accepted normally; reset asserted in RD_ADDR → ack never asserted.
- SRAM_WB_LINEBUF_EN:
  - two reads to row 5 → second acked after 1 edge with no read_csb pulse;
  - write to row 5, then read → 3-edge SRAM path returns new data.

Source files
------------

// File: rtl/sram_wb_bridge.sv
// Wishbone classic 32-bit slave driving a dual-port 64-bit-row SRAM macro.
// Optional one-entry row buffer for read hits: define SRAM_WB_LINEBUF_EN.
module sram_wb_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WMASKS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH+2:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  sram_write_csb,
    output logic                  sram_write_web,
    output logic [NUM_WMASKS-1:0] sram_write_wmask,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic                  sram_read_csb,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, ACK} state_t;

    state_t                  state_reg, state_next;
    logic                    half_reg, half_next;
    logic                    write_csb_reg, write_csb_next;
    logic                    write_web_reg, write_web_next;
    logic [NUM_WMASKS-1:0]   wmask_reg, wmask_next;
    logic [ADDR_WIDTH-1:0]   write_addr_reg, write_addr_next;
    logic [DATA_WIDTH-1:0]   write_data_reg, write_data_next;
    logic                    read_csb_reg, read_csb_next;
    logic [ADDR_WIDTH-1:0]   read_addr_reg, read_addr_next;
    logic                    ack_reg, ack_next;
    logic [31:0]             dat_reg, dat_next;

    logic [ADDR_WIDTH-1:0]   req_row;
    logic                    req_half;
    logic [NUM_WMASKS-1:0]   req_mask;
    logic [31:0]             rd_half_data;
    logic                    unused_adr_bits;

    assign req_row         = wb_adr_i[ADDR_WIDTH+2:3];
    assign req_half        = wb_adr_i[2];
    assign unused_adr_bits = ^wb_adr_i[1:0];
    assign rd_half_data    = half_reg ? sram_read_data[63:32] : sram_read_data[31:0];

    // Byte lanes 4..7 belong to the upper bus half, lanes 0..3 to the lower.
    generate
        for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_mask
            assign req_mask[gi] = ((gi / 4) == int'(req_half)) ? wb_sel_i[gi % 4] : 1'b0;
        end
    endgenerate

`ifdef SRAM_WB_LINEBUF_EN
    logic                    lb_valid_reg, lb_valid_next;
    logic [ADDR_WIDTH-1:0]   lb_tag_reg, lb_tag_next;
    logic [DATA_WIDTH-1:0]   lb_data_reg, lb_data_next;
    logic                    lb_hit;

    assign lb_hit = lb_valid_reg && (lb_tag_reg == req_row);
`endif

    always_comb begin
        state_next      = state_reg;
        half_next       = half_reg;
        write_csb_next  = write_csb_reg;
        write_web_next  = write_web_reg;
        wmask_next      = wmask_reg;
        write_addr_next = write_addr_reg;
        write_data_next = write_data_reg;
        read_csb_next   = read_csb_reg;
        read_addr_next  = read_addr_reg;
        ack_next        = 1'b0;
        dat_next        = dat_reg;
`ifdef SRAM_WB_LINEBUF_EN
        lb_valid_next   = lb_valid_reg;
        lb_tag_next     = lb_tag_reg;
        lb_data_next    = lb_data_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    half_next = req_half;
                    if (wb_we_i) begin
                        write_csb_next  = 1'b0;
                        write_web_next  = 1'b0;
                        write_addr_next = req_row;
                        write_data_next = {wb_dat_i, wb_dat_i};
                        wmask_next      = req_mask;
                        state_next      = WR;
`ifdef SRAM_WB_LINEBUF_EN
                        if (lb_hit) begin
                            lb_valid_next = 1'b0;
                        end
`endif
                    end
`ifdef SRAM_WB_LINEBUF_EN
                    else if (lb_hit) begin
                        dat_next   = req_half ? lb_data_reg[63:32] : lb_data_reg[31:0];
                        ack_next   = 1'b1;
                        state_next = ACK;
                    end
`endif
                    else begin
                        read_csb_next  = 1'b0;
                        read_addr_next = req_row;
                        state_next     = RD_ADDR;
                    end
                end
            end
            WR: begin
                write_csb_next = 1'b1;
                write_web_next = 1'b1;
                ack_next       = wb_cyc_i;
                state_next     = wb_cyc_i ? ACK : IDLE;
            end
            RD_ADDR: begin
                read_csb_next = 1'b1;
                state_next    = RD_CAP;
            end
            RD_CAP: begin
`ifdef SRAM_WB_LINEBUF_EN
                lb_valid_next = 1'b1;
                lb_tag_next   = read_addr_reg;
                lb_data_next  = sram_read_data;
`endif
                // A master that dropped cyc gets no ack and keeps its old read data.
                if (wb_cyc_i) begin
                    dat_next   = rd_half_data;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end else begin
                    state_next = IDLE;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            half_reg       <= 1'b0;
            write_csb_reg  <= 1'b1;
            write_web_reg  <= 1'b1;
            wmask_reg      <= '0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            read_csb_reg   <= 1'b1;
            read_addr_reg  <= '0;
            ack_reg        <= 1'b0;
            dat_reg        <= '0;
`ifdef SRAM_WB_LINEBUF_EN
            lb_valid_reg   <= 1'b0;
            lb_tag_reg     <= '0;
            lb_data_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            half_reg       <= half_next;
            write_csb_reg  <= write_csb_next;
            write_web_reg  <= write_web_next;
            wmask_reg      <= wmask_next;
            write_addr_reg <= write_addr_next;
            write_data_reg <= write_data_next;
            read_csb_reg   <= read_csb_next;
            read_addr_reg  <= read_addr_next;
            ack_reg        <= ack_next;
            dat_reg        <= dat_next;
`ifdef SRAM_WB_LINEBUF_EN
            lb_valid_reg   <= lb_valid_next;
            lb_tag_reg     <= lb_tag_next;
            lb_data_reg    <= lb_data_next;
`endif
        end
    end

    assign wb_dat_o         = dat_reg;
    assign wb_ack_o         = ack_reg;
    assign sram_write_csb   = write_csb_reg;
    assign sram_write_web   = write_web_reg;
    assign sram_write_wmask = wmask_reg;
    assign sram_write_addr  = write_addr_reg;
    assign sram_write_data  = write_data_reg;
    assign sram_read_csb    = read_csb_reg;
    assign sram_read_addr   = read_addr_reg;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Scoreboard bench for sram_wb_bridge: a driver queues expected acks and SRAM
// cycles, a negedge monitor pops and compares them; an SRAM model serves reads.
module tb_sram_wb_bridge;

`ifdef SRAM_WB_LINEBUF_EN
    localparam int   HIT_LAT   = 1;
    localparam logic HIT_PULSE = 1'b0;
`else
    localparam int   HIT_LAT   = 3;
    localparam logic HIT_PULSE = 1'b1;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [10:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        write_csb, write_web, read_csb;
    logic [7:0]  wmask, write_addr, read_addr;
    logic [63:0] write_data, read_data;

    logic [63:0] mem [256];
    logic [31:0] ack_q [$];
    wr_t         wr_q [$];
    logic [7:0]  rd_q [$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    sram_wb_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .NUM_WMASKS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .sram_write_csb(write_csb), .sram_write_web(write_web),
        .sram_write_wmask(wmask), .sram_write_addr(write_addr),
        .sram_write_data(write_data), .sram_read_csb(read_csb),
        .sram_read_addr(read_addr), .sram_read_data(read_data)
    );

    // SRAM macro model: byte-masked write port, one-cycle read latency.
    always @(posedge clk) begin
        if (write_csb === 1'b0 && write_web === 1'b0) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) mem[write_addr][b*8 +: 8] <= write_data[b*8 +: 8];
            end
        end
        if (read_csb === 1'b0) read_data <= mem[read_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Monitor: compares every ack and every SRAM cycle against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (write_csb === 1'b0 && read_csb === 1'b0) unexpected("both_csb_low");
            if (ack === 1'b1) begin
                check("ack_width", {63'd0, prev_ack}, 64'd0);
                if (ack_q.size() == 0) unexpected("unexpected_ack");
                else check("dat_o", {32'd0, dat_o}, {32'd0, ack_q.pop_front()});
            end
            if (write_csb === 1'b0) begin
                if (wr_q.size() == 0) unexpected("unexpected_write");
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("write_web", {63'd0, write_web}, 64'd0);
                    check("write_addr", {56'd0, write_addr}, {56'd0, e.addr});
                    check("write_mask", {56'd0, wmask}, {56'd0, e.mask});
                    check("write_data", write_data, e.data);
                end
            end
            if (read_csb === 1'b0) begin
                if (rd_q.size() == 0) unexpected("unexpected_read");
                else check("read_addr", {56'd0, read_addr}, {56'd0, rd_q.pop_front()});
            end
        end
        prev_ack <= (ack === 1'b1);
    end

    task automatic xfer(input logic w, input logic [10:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int exp_lat, input logic [7:0] exp_row,
                        input logic [7:0] exp_mask, input logic [31:0] exp_dat,
                        input logic pulse);
        int n;
        if (w) wr_q.push_back('{exp_row, exp_mask, {d, d}});
        else if (pulse) rd_q.push_back(exp_row);
        ack_q.push_back(exp_dat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack !== 1'b1 && n < 8);
        check("latency", 64'(n), 64'(exp_lat));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
        check("ack_single_cycle", {63'd0, ack}, 64'd0);
        $display("xfer we=%0d adr=%h sel=%h dat_i=%h dat_o=%h latency=%0d", w, a, sel, d, dat_o, n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_write_csb"}, {63'd0, write_csb}, 64'd1);
        check({tag, "_read_csb"}, {63'd0, read_csb}, 64'd1);
        check({tag, "_web"}, {63'd0, write_web}, 64'd1);
        check({tag, "_ack"}, {63'd0, ack}, 64'd0);
        check({tag, "_dat_o"}, {32'd0, dat_o}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        read_data = 64'd0;
        rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 11'h00C; sel = 4'hF; dat_i = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_wmask", {56'd0, wmask}, 64'd0);
        check("reset_write_addr", {56'd0, write_addr}, 64'd0);
        check("reset_read_addr", {56'd0, read_addr}, 64'd0);
        check("reset_write_data", write_data, 64'd0);
        $display("reset released");
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        mon_en = 1'b1;

        // Full-word write to the upper half of row 1.
        xfer(1'b1, 11'h00C, 4'hF, 32'hDEADBEEF, 2, 8'h01, 8'hF0, 32'h0, 1'b0);
        check("mem_row1_hi", {32'd0, mem[1][63:32]}, 64'hDEADBEEF);
        mem[1] = 64'h11112222_33334444;
        xfer(1'b0, 11'h00C, 4'hF, 32'h0, 3, 8'h01, 8'h00, 32'h11112222, 1'b1);
        xfer(1'b0, 11'h008, 4'hF, 32'h0, HIT_LAT, 8'h01, 8'h00, 32'h33334444, HIT_PULSE);

        // Byte write on the top row, then an empty-mask write; dat_o must hold.
        xfer(1'b1, 11'h7F8, 4'h4, 32'hA5A5A5A5, 2, 8'hFF, 8'h04, 32'h33334444, 1'b0);
        xfer(1'b1, 11'h7F8, 4'h0, 32'h12345678, 2, 8'hFF, 8'h00, 32'h33334444, 1'b0);
        xfer(1'b0, 11'h7F8, 4'hF, 32'h0, 3, 8'hFF, 8'h00, 32'h00A50000, 1'b1);

        // Abort: cyc dropped right after the read request is sampled.
        rd_q.push_back(8'h02);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 11'h010;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_ack", {63'd0, ack}, 64'd0);
        $display("abort read adr=%h", 11'h010);
        xfer(1'b1, 11'h014, 4'h3, 32'h0000BEEF, 2, 8'h02, 8'h30, 32'h00A50000, 1'b0);

        // Reset asserted while the FSM sits in RD_ADDR.
        rd_q.push_back(8'h02);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 11'h014;
        @(posedge clk);
        #1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        $display("reset during read adr=%h", 11'h014);
        xfer(1'b0, 11'h014, 4'hF, 32'h0, 3, 8'h02, 8'h00, 32'h0000BEEF, 1'b1);

        // Row 5: repeated read, then a write that must invalidate any cached copy.
        mem[5] = 64'h55556666_77778888;
        xfer(1'b0, 11'h028, 4'hF, 32'h0, 3, 8'h05, 8'h00, 32'h77778888, 1'b1);
        xfer(1'b0, 11'h02C, 4'hF, 32'h0, HIT_LAT, 8'h05, 8'h00, 32'h55556666, HIT_PULSE);
        xfer(1'b1, 11'h02C, 4'hF, 32'hCAFEF00D, 2, 8'h05, 8'hF0, 32'h55556666, 1'b0);
        xfer(1'b0, 11'h02C, 4'hF, 32'h0, 3, 8'h05, 8'h00, 32'hCAFEF00D, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("ack_q_empty", 64'(ack_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
